// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer for one external MAC unit.
// Takes a job length, streams N operand pairs into the MAC and returns Cout.
module mac_seq_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    start_len,
  output logic                    start_ready,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [DATA_WIDTH-1:0]   a_data,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [DATA_WIDTH-1:0]   b_data,
  output logic                    mac_en,
  output logic                    mac_clr,
  output logic [DATA_WIDTH-1:0]   mac_ain,
  output logic [DATA_WIDTH-1:0]   mac_bin,
  input  logic [3*DATA_WIDTH-1:0] mac_cout,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [3*DATA_WIDTH-1:0] res_data,
  output logic                    busy
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    WAIT,
    DONE
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [LEN_WIDTH-1:0] cnt;
  logic                 pair_fire;
  logic                 last_pair;

  // Both operands move together; one stream is never drained alone.
  assign pair_fire = (state == RUN) & a_valid & b_valid;
  assign last_pair = pair_fire & (cnt == LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        state_nxt = (cnt != '0) ? RUN : WAIT;
      end
      RUN: begin
        if (last_pair) state_nxt = WAIT;
      end
      WAIT: begin
        state_nxt = DONE;
      end
      DONE: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    start_ready = 1'b0;
    a_ready     = 1'b0;
    b_ready     = 1'b0;
    mac_en      = 1'b0;
    mac_clr     = 1'b0;
    mac_ain     = '0;
    mac_bin     = '0;
    res_valid   = 1'b0;
    busy        = (state != IDLE);
    unique case (state)
      IDLE: begin
        start_ready = 1'b1;
      end
      CLEAR: begin
        mac_clr = 1'b1;
      end
      RUN: begin
        a_ready = pair_fire;
        b_ready = pair_fire;
        mac_en  = pair_fire;
        mac_ain = a_data;
        mac_bin = b_data;
      end
      WAIT: begin
      end
      DONE: begin
        res_valid = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // WAIT gives the MAC register one edge to absorb the final product.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      res_data <= '0;
    end else begin
      if (state == IDLE && start) begin
        cnt <= start_len;
      end else if (pair_fire) begin
        cnt <= cnt - LEN_WIDTH'(1);
      end
      if (state == WAIT) begin
        res_data <= mac_cout;
      end
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural MAC attached.
// Expected dot products are hand-computed constants.
module tb_mac_seq_ctrl;
  localparam int DW = 8;
  localparam int LW = 8;
  localparam int AW = 3 * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] start_len;
  logic          start_ready;
  logic          a_valid;
  logic          a_ready;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [DW-1:0] b_data;
  logic          mac_en;
  logic          mac_clr;
  logic [DW-1:0] mac_ain;
  logic [DW-1:0] mac_bin;
  logic [AW-1:0] mac_cout;
  logic          res_valid;
  logic          res_ready;
  logic [AW-1:0] res_data;
  logic          busy;

  logic [AW-1:0] acc = '0;
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_seq_ctrl #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_len  (start_len),
    .start_ready(start_ready),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_data     (b_data),
    .mac_en     (mac_en),
    .mac_clr    (mac_clr),
    .mac_ain    (mac_ain),
    .mac_bin    (mac_bin),
    .mac_cout   (mac_cout),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .busy       (busy)
  );

  // external MAC: registered accumulator, clear has priority
  always @(posedge clk) begin
    if (mac_clr) acc <= '0;
    else if (mac_en) acc <= acc + AW'(mac_ain) * AW'(mac_bin);
  end
  assign mac_cout = acc;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_outs(input string tag);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " rv"}, 64'(res_valid), 64'd0);
    chk({tag, " sr"}, 64'(start_ready), 64'd1);
    chk({tag, " en"}, 64'(mac_en), 64'd0);
    chk({tag, " clr"}, 64'(mac_clr), 64'd0);
    chk({tag, " rdy"}, 64'({a_ready, b_ready}), 64'd0);
    chk({tag, " ab"}, 64'({mac_ain, mac_bin}), 64'd0);
  endtask

  // mode 0: both streams always valid; mode 1: bubbly, misaligned valids
  task automatic run_job(input string tag, input int len, input int mode,
                         input int exp, input bit poke);
    int c, idx, clr_n, clr_c, en_n, bad_rdy, bad_pass, sr_hi;
    int fire_last, res_c;
    c = 1; idx = 0; clr_n = 0; clr_c = -1; en_n = 0;
    bad_rdy = 0; bad_pass = 0; sr_hi = 0;
    fire_last = -1; res_c = -1;
    start = 1'b1;
    start_len = LW'(len);
    #1;
    chk({tag, " start_ready"}, 64'(start_ready), 64'd1);
    tick();
    start = poke;
    start_len = 8'd9;
    while (c < 3000) begin
      if (idx < len) begin
        a_data  = qa[idx];
        b_data  = qb[idx];
        a_valid = (mode == 0) ? 1'b1 : c[0];
        b_valid = (mode == 0) ? 1'b1 : (c % 3 == 0);
      end else begin
        a_valid = 1'b0;
        b_valid = 1'b0;
      end
      #1;
      if (res_valid) begin
        res_c = c;
        break;
      end
      if (mac_clr) begin
        clr_n++;
        clr_c = c;
      end
      if (start_ready) sr_hi++;
      if (a_ready != b_ready) bad_rdy++;
      if (a_ready && !(a_valid && b_valid)) bad_rdy++;
      if (mac_en) begin
        en_n++;
        if (mac_ain != a_data || mac_bin != b_data) bad_pass++;
      end
      if (a_ready) begin
        idx++;
        fire_last = c;
      end
      tick();
      c++;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    chk({tag, " finished"}, 64'(res_c >= 0), 64'd1);
    chk({tag, " clr_pulses"}, 64'(clr_n), 64'd1);
    chk({tag, " en_cycles"}, 64'(en_n), 64'(len));
    chk({tag, " one_sided"}, 64'(bad_rdy), 64'd0);
    chk({tag, " passthru"}, 64'(bad_pass), 64'd0);
    chk({tag, " sr_busy"}, 64'(sr_hi), 64'd0);
    chk({tag, " res_data"}, 64'(res_data), 64'(exp));
    if (mode == 0) chk({tag, " lat_start"}, 64'(res_c), 64'(len + 3));
    if (len > 0) chk({tag, " lat_fire"}, 64'(res_c - fire_last), 64'd2);
    else chk({tag, " lat_clr"}, 64'(res_c - clr_c), 64'd2);
    res_ready = 1'b0;
    repeat (10) tick();
    chk({tag, " hold_rv"}, 64'(res_valid), 64'd1);
    chk({tag, " hold_data"}, 64'(res_data), 64'(exp));
    chk({tag, " hold_sr"}, 64'(start_ready), 64'd0);
    chk({tag, " hold_busy"}, 64'(busy), 64'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    start = 1'b0;
    #1;
    idle_outs({tag, " after"});
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    start_len = '0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_data = '0;
    b_data = '0;
    res_ready = 1'b0;
    tick();
    tick();
    idle_outs("reset");
    chk("reset res_data", 64'(res_data), 64'd0);
    rst_n = 1'b1;
    tick();

    qa = '{8'd1, 8'd2, 8'd3};
    qb = '{8'd4, 8'd5, 8'd6};
    run_job("dot3", 3, 0, 32, 1'b0);
    run_job("dot3_bub", 3, 1, 32, 1'b0);
    run_job("len0", 0, 0, 0, 1'b0);

    qa.delete();
    qb.delete();
    repeat (255) begin
      qa.push_back(8'd255);
      qb.push_back(8'd255);
    end
    run_job("len255", 255, 0, 16581375, 1'b0);
    qa = '{8'd7};
    qb = '{8'd9};
    run_job("len1", 1, 0, 63, 1'b0);

    qa = '{8'd1, 8'd2, 8'd3};
    qb = '{8'd4, 8'd5, 8'd6};
    run_job("poke", 3, 0, 32, 1'b1);

    // abort mid-job after two of three pairs
    start = 1'b1;
    start_len = 8'd3;
    tick();
    start = 1'b0;
    tick();
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data = 8'd1;
    b_data = 8'd4;
    tick();
    a_data = 8'd2;
    b_data = 8'd5;
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    idle_outs("abort");
    chk("abort res_data", 64'(res_data), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("abort stay_idle", 64'(busy), 64'd0);
    chk("abort no_rv", 64'(res_valid), 64'd0);

    qa = '{8'd2, 8'd3};
    qb = '{8'd5, 8'd5};
    run_job("post_rst", 2, 0, 25, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Sequencer that drives one MAC datapath unit and performs a complete dot product of length N. It accepts a job (a length), then consumes N operand pairs from two valid/ready streams. It drives the MAC's En/Clr/Ain/Bin, waits for the final accumulation, and returns the Cout value on a valid/ready result port. The MAC instance sits outside this block; the block is the initiator side of the MAC's En/Clr/Cout interface.

Parameters:
DATA_WIDTH, 8, operand width; must match the driven MAC instance.
LEN_WIDTH, 8, width of the job length field (max N = 2^LEN_WIDTH-1).

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
start  input  1  job request, qualified by start_ready
start_len  input  LEN_WIDTH  number of operand pairs N
start_ready  output  1  high in IDLE only
a_valid / a_ready  in / out  1  A stream handshake
a_data  input  DATA_WIDTH  A operand
b_valid / b_ready  in / out  1  B stream handshake
b_data  input  DATA_WIDTH  B operand
mac_en  output  1  to MAC En
mac_clr  output  1  to MAC Clr
mac_ain  output  DATA_WIDTH  to MAC Ain
mac_bin  output  DATA_WIDTH  to MAC Bin
mac_cout  input  3*DATA_WIDTH  from MAC Cout
res_valid  output  1  result available
res_ready  input  1  result consumer ready
res_data  output  3*DATA_WIDTH  captured dot product
busy  output  1  state != IDLE

Behaviour:
- Reset is synchronous on posedge clk when rst_n=0. It forces the state to IDLE and clears the remaining-count and res_data to 0. It applies at any point, including mid-job; the partial job is abandoned with no result. After reset: res_valid=0, busy=0, mac_en=0, mac_clr=0, a_ready=b_ready=0.
- States:
  - IDLE: start_ready=1. start=1 latches start_len into cnt and moves to CLEAR.
  - CLEAR: mac_clr=1 for exactly one cycle. Next state is RUN if cnt!=0, otherwise WAIT.
  - RUN: pair_fire = a_valid & b_valid.
    - a_ready = b_ready = a_valid & b_valid. A single stream is never consumed alone.
    - mac_en = pair_fire; mac_ain = a_data and mac_bin = b_data (combinational pass-through).
    - On pair_fire, cnt decrements. If cnt==1 at fire, go to WAIT. Bubbles stall with no penalty.
  - WAIT: one cycle, so the MAC register absorbs the last product. Capture res_data <= mac_cout, then go to DONE.
  - DONE: res_valid=1 and res_data held stable. res_ready=1 returns to IDLE (res_valid drops the next cycle). No timeout.
- Outputs outside RUN: mac_en=0, a_ready=b_ready=0, mac_ain=mac_bin=0. mac_clr is high only in CLEAR.
- start is ignored (not latched) when not in IDLE.
- Latency:
  - start accept to first possible pair fire: 2 cycles.
  - Last pair fire to res_valid: 2 cycles.
  - Minimum job of N pairs with no bubbles, start edge to res_valid: N+3 cycles.
- Arithmetic: accumulation width is 3*DATA_WIDTH, unsigned, wrapping modulo 2^(3*DATA_WIDTH), exactly as the MAC produces it. This block adds no saturation.
- N=0: the MAC is cleared and res_data=0 is returned without consuming any operands.
- The MAC is always cleared at job start, so successive jobs are independent.

Test Plan:
- start_len=3, A={1,2,3}, B={4,5,6}, both valid continuously -> mac_clr pulses once; mac_en high 3 cycles; res_valid 2 cycles after last fire; res_data=32; res_valid stays until res_ready.
- Same job, a_valid toggling 1/0 and b_valid delayed 2 cycles per element -> no fire unless both valid; never a one-sided ready; res_data=32.
- start_len=0 -> no a_ready/b_ready ever; res_data=0; res_valid 2 cycles after CLEAR.
- start_len=255, A=B=255 every element -> res_data=16581375 (0xFD02FF); then second job len=1, A=7, B=9 -> res_data=63 (clear verified).
- start pulsed during RUN and DONE -> ignored; start_ready=0. res_ready held low 10 cycles in DONE -> res_data stable, res_valid held.
- rst_n=0 for one cycle after 2 of 3 pairs -> next cycle IDLE, busy=0, all outputs zero, no res_valid. A new job len=2, A={2,3}, B={5,5} -> 25.
